seg_bcd_converter: RTL and testbench
====================================

# seg_bcd_converter

Sequential binary-to-BCD converter feeding the 8-digit seven-segment output stage. It accepts a 32-bit value from the CPU's display MMIO path, signed or unsigned, and converts it to eight packed BCD digits by iterative double-dabble, one bit per cycle. The packed `bcd` word connects directly to the display driver's 32-bit `x` input, so the display shows decimal instead of hex.

## Interface
- No parameters. Input width is fixed at 32 bits; output is fixed at 8 BCD digits.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin`  in  32  value to convert; sampled on the accepting edge only.
- `is_signed`  in  1  treat `bin` as two's complement; sampled with `bin`.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when the results below update.
- `bcd`  out  32  packed BCD: digit k in bits [4k+3:4k], digit 0 = units; held between completions.
- `overflow`  out  1  magnitude > 99,999,999; held.
- `neg`  out  1  input was negative in signed mode; held.

## Operation
- FSM has two states.
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1; 5-bit iteration counter runs 0..31.
- Accept (IDLE with `start`=1):
  - mag = (`is_signed` && `bin`[31]) ? -`bin` : `bin`, computed as a 32-bit unsigned value. 0x80000000 gives 2,147,483,648.
  - Latch neg_pending from the same condition.
  - Load shift register {40-bit BCD accumulator = 0, mag}. Clear counter. Go to SHIFT.
- Each SHIFT cycle:
  - For each of the 10 accumulator digits, add 3 if the digit is ≥ 5.
  - Then shift the 72-bit {acc, mag} left by 1.
  - Increment the counter.
- At the edge performing iteration 31:
  - `bcd` ← corrected/shifted acc[31:0].
  - `overflow` ← (acc[39:32] != 0).
  - `neg` ← neg_pending.
  - `done` ← 1; `busy` ← 0; go to IDLE.
- Overflow case: `bcd` carries the low 8 decimal digits. Downstream decides whether to blank.
- `start` while SHIFT is ignored (not queued). `bin`/`is_signed` changes during SHIFT have no effect.
- `done` is registered and cleared on the following edge unless a new completion occurs.
- Reset: state IDLE, counter 0, accumulator 0. Outputs reset to `busy`=0, `done`=0, `bcd`=0x00000000, `overflow`=0, `neg`=0. A conversion in progress is discarded with no `done`.

## Timing
- Edge E0 samples `start`=1 in IDLE. `busy`=1 from E0 through E32.
- Iterations run at E1..E32.
- Outputs update, and `done`=1, in the cycle after E32. `busy` is 0 in that same cycle.
- Latency: exactly 32 cycles from the accepting edge to the `done` cycle, independent of data.
- Throughput: a `start` held high during the `done` cycle is accepted (state is IDLE). Back-to-back conversions take one every 33 cycles.
- `bcd`/`overflow`/`neg` change only on the `done` edge or on reset. No intermediate values are visible.
- Reset asserted on the same edge as `start`: reset wins.

## Test plan
- Reset, then `bin`=12345678 (0x00BC614E), `is_signed`=0, one-cycle `start` -> `busy` high for 32 cycles, then a single `done` pulse with `bcd`=0x12345678, `overflow`=0, `neg`=0; outputs hold afterwards.
- Boundaries, unsigned:
  - 0 -> `bcd`=0x00000000.
  - 99,999,999 -> 0x99999999, `overflow`=0.
  - 100,000,000 -> 0x00000000, `overflow`=1.
  - 0xFFFFFFFF -> 0x94967295, `overflow`=1.
- Signed:
  - 0xFFFFFFFF -> `bcd`=0x00000001, `neg`=1.
  - 0x80000000 -> 0x47483648, `neg`=1, `overflow`=1.
  - 0xFFFFFFFF with `is_signed`=0 -> `neg`=0.
- `start` re-pulsed at cycles 5 and 20 of a conversion, with `bin` changed -> ignored; the first result is correct; exactly one `done`.
- `rst` asserted at iteration 10 -> next cycle `busy`=0, `bcd`=0, `done` never pulses. A new conversion of 42 then yields 0x00000042.
- `start` held high continuously with `bin`=7 -> `done` every 33 cycles, `bcd`=0x00000007 each time.

Source files
------------

// File: rtl/seg_bcd_converter.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (double-dabble, one bit per cycle).
// Signed inputs are converted by magnitude, and the sign is reported separately on neg.
module seg_bcd_converter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin,
    input  logic        is_signed,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        overflow,
    output logic        neg
);

    // state  | meaning
    // IDLE   | waiting for start; results held
    // SHIFT  | 32 double-dabble iterations in progress
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [71:0] shift_reg;
    logic [4:0]  iter_cnt;
    logic        neg_pending;

    logic        is_neg_in;
    logic [31:0] mag;
    logic [39:0] acc_adj;
    logic [71:0] shift_nxt;
    logic        last_iter;

    assign is_neg_in = is_signed & bin[31];
    assign mag       = is_neg_in ? (~bin + 32'd1) : bin;
    assign last_iter = (iter_cnt == 5'd31);
    assign busy      = (state == ST_SHIFT);

    // Add-3 correction on every accumulator digit, then shift the whole register left.
    always_comb begin
        acc_adj = shift_reg[71:32];
        for (int k = 0; k < 10; k++) begin
            if (shift_reg[32+4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = shift_reg[32+4*k +: 4] + 4'd3;
        end
        shift_nxt = {acc_adj[38:0], shift_reg[31:0], 1'b0};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)     state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_iter) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            iter_cnt    <= '0;
            neg_pending <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
            neg         <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg   <= {40'd0, mag};
                        iter_cnt    <= '0;
                        neg_pending <= is_neg_in;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_nxt;
                    iter_cnt  <= iter_cnt + 5'd1;
                    if (last_iter) begin
                        bcd      <= shift_nxt[63:32];
                        overflow <= (shift_nxt[71:64] != 8'd0);
                        neg      <= neg_pending;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bcd_converter.sv
// Directed self-checking bench for seg_bcd_converter.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_seg_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bin;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        overflow;
    logic        neg;

    int errors = 0;
    int checks = 0;

    seg_bcd_converter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .overflow  (overflow),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse, then follow the conversion to its done cycle and one cycle beyond.
    task automatic run_conv(input logic [31:0] v, input logic s, input logic [31:0] e_bcd,
                            input logic e_ovf, input logic e_neg, input string tag);
        int lat;
        int busy_cnt;
        start = 1'b1; bin = v; is_signed = s;
        tick();
        start = 1'b0; bin = 32'hDEAD_BEEF; is_signed = ~s;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        chk({tag, " latency"}, lat, 32);
        chk({tag, " busy_cycles"}, busy_cnt, 32);
        chk({tag, " busy_in_done"}, {31'd0, busy}, 0);
        chk({tag, " bcd"}, bcd, e_bcd);
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, e_ovf});
        chk({tag, " neg"}, {31'd0, neg}, {31'd0, e_neg});
        tick();
        chk({tag, " done_drop"}, {31'd0, done}, 0);
        chk({tag, " bcd_hold"}, bcd, e_bcd);
    endtask

    initial begin
        int lat;
        int dones;
        int first_done;
        int done_at[$];
        logic [31:0] first_bcd;

        // reset coinciding with start: reset wins
        rst = 1'b1; start = 1'b1; bin = 32'd5; is_signed = 1'b0;
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset bcd", bcd, 32'h0000_0000);
        chk("reset overflow", {31'd0, overflow}, 0);
        chk("reset neg", {31'd0, neg}, 0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        run_conv(32'h00BC_614E, 1'b0, 32'h1234_5678, 1'b0, 1'b0, "u12345678");
        run_conv(32'd0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, "u0");
        run_conv(32'd99999999,  1'b0, 32'h9999_9999, 1'b0, 1'b0, "u99999999");
        run_conv(32'd100000000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "u100000000");
        run_conv(32'hFFFF_FFFF, 1'b0, 32'h9496_7295, 1'b1, 1'b0, "uFFFFFFFF");
        run_conv(32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0, 1'b1, "sFFFFFFFF");
        run_conv(32'h8000_0000, 1'b1, 32'h4748_3648, 1'b1, 1'b1, "s80000000");
        run_conv(32'd1234,      1'b1, 32'h0000_1234, 1'b0, 1'b0, "s1234");

        // start re-pulsed mid-conversion with different data
        start = 1'b1; bin = 32'd87654321; is_signed = 1'b0;
        tick();
        start = 1'b0;
        dones = 0; first_done = -1; first_bcd = '0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5 || c == 20) begin
                start = 1'b1; bin = 32'd11111111;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dones++;
                if (first_done < 0) begin
                    first_done = c;
                    first_bcd = bcd;
                end
            end
        end
        start = 1'b0;
        chk("repulse done_count", dones, 1);
        chk("repulse latency", first_done, 32);
        chk("repulse bcd", first_bcd, 32'h8765_4321);

        // reset at iteration 10 discards the conversion
        start = 1'b1; bin = 32'd555; is_signed = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid busy", {31'd0, busy}, 0);
        chk("rst_mid bcd", bcd, 32'h0000_0000);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dones++;
            tick();
        end
        chk("rst_mid no_done", dones, 0);
        run_conv(32'd42, 1'b0, 32'h0000_0042, 1'b0, 1'b0, "after_rst42");

        // start held high: one result every 33 cycles
        start = 1'b1; bin = 32'd7; is_signed = 1'b0;
        tick();
        lat = 0;
        while (done_at.size() < 3 && lat < 120) begin
            tick();
            lat++;
            if (done) begin
                done_at.push_back(lat);
                chk("held bcd", bcd, 32'h0000_0007);
            end
        end
        start = 1'b0;
        chk("held done_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("held first", done_at[0], 32);
            chk("held interval1", done_at[1] - done_at[0], 33);
            chk("held interval2", done_at[2] - done_at[1], 33);
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("final_reset busy", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
